// File: rtl/stopwatch_timer_core_if.sv
// Control/display bundle between the input conditioning stage and stopwatch_timer_core.
// master: drives the request/level inputs; slave: the timer core that produces the BCD display.
interface stopwatch_timer_core_if;
  logic        pause_pulse;
  logic        lap_pulse;
  logic        adj;
  logic        sel;
  logic        dir;
  logic [15:0] digits;
  logic        running;
  logic        expired;
  logic        blink;
  logic        adj_field;

  modport master (
    output pause_pulse, lap_pulse, adj, sel, dir,
    input  digits, running, expired, blink, adj_field
  );

  modport slave (
    input  pause_pulse, lap_pulse, adj, sel, dir,
    output digits, running, expired, blink, adj_field
  );
endinterface

// File: rtl/stopwatch_timer_core.sv
// Single-clock stopwatch/countdown engine with clock-enable prescalers, BCD MM:SS output.
// Optional lap hold is built when STOPWATCH_LAP_EN is defined.
module stopwatch_timer_core #(
  parameter int CLK_HZ   = 100000000,
  parameter int TICK_HZ  = 1,
  parameter int ADJ_HZ   = 2,
  parameter int BLINK_HZ = 2,
  parameter int MAX_MIN  = 59
) (
  input  logic                   clk,
  input  logic                   reset,
  stopwatch_timer_core_if.slave  bus
);

  localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
  localparam int ADJ_DIV   = CLK_HZ / ADJ_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int TICK_W    = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int ADJ_W     = (ADJ_DIV   > 1) ? $clog2(ADJ_DIV)   : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TICK_W-1:0]  TICK_TERM  = TICK_W'(TICK_DIV - 1);
  localparam logic [ADJ_W-1:0]   ADJ_TERM   = ADJ_W'(ADJ_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_TERM = BLINK_W'(BLINK_DIV - 1);

  localparam logic [7:0]  SEC_MAX = 8'h59;
  localparam logic [7:0]  MIN_MAX = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [15:0] ONE_SEC = 16'h0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_ADJUST,
    S_EXPIRED
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          value_q, value_d;
  logic                 dir_q, dir_d;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [ADJ_W-1:0]     adj_cnt_q;
  logic [BLINK_W-1:0]   blink_cnt_q;
  logic                 blink_q, running_q, expired_q, adj_field_q;
  logic                 tick, adj_tick;
  logic                 stay_run, stay_adjust;

  // Two-digit BCD step with wrap at max_v; digits stay 0..9 by construction.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v == max_v)       return 8'h00;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
    if (v == 8'h00)       return max_v;
    if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [15:0] count_up(input logic [15:0] v);
    return {(v[7:0] == SEC_MAX) ? bcd_inc(v[15:8], MIN_MAX) : v[15:8], bcd_inc(v[7:0], SEC_MAX)};
  endfunction

  function automatic logic [15:0] count_down(input logic [15:0] v);
    return {(v[7:0] == 8'h00) ? bcd_dec(v[15:8], MIN_MAX) : v[15:8], bcd_dec(v[7:0], SEC_MAX)};
  endfunction

  assign tick        = (state_q == S_RUN)    && (tick_cnt_q == TICK_TERM);
  assign adj_tick    = (state_q == S_ADJUST) && (adj_cnt_q == ADJ_TERM);
  assign stay_run    = (state_q == S_RUN)    && (state_d == S_RUN);
  assign stay_adjust = (state_q == S_ADJUST) && (state_d == S_ADJUST);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    dir_d   = dir_q;
    unique case (state_q)
      S_IDLE, S_PAUSED: begin
        if (bus.adj) begin
          state_d = S_ADJUST;
        end else if (bus.pause_pulse && !(bus.dir && value_q == 16'h0000)) begin
          state_d = S_RUN;
          dir_d   = bus.dir;
        end
      end
      S_RUN: begin
        // Leaving RUN discards a coincident tick.
        if (bus.adj) begin
          state_d = S_ADJUST;
        end else if (bus.pause_pulse) begin
          state_d = S_PAUSED;
        end else if (tick) begin
          if (!dir_q) begin
            value_d = count_up(value_q);
          end else if (value_q == ONE_SEC) begin
            value_d = 16'h0000;
            state_d = S_EXPIRED;
          end else begin
            value_d = count_down(value_q);
          end
        end
      end
      S_ADJUST: begin
        if (adj_tick) begin
          if (bus.sel) value_d = {value_q[15:8], bcd_inc(value_q[7:0], SEC_MAX)};
          else         value_d = {bcd_inc(value_q[15:8], MIN_MAX), value_q[7:0]};
        end
        if (!bus.adj) state_d = S_PAUSED;
      end
      S_EXPIRED: begin
        value_d = 16'h0000;
        if (bus.adj)              state_d = S_ADJUST;
        else if (bus.pause_pulse) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        value_d = 16'h0000;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      value_q     <= '0;
      dir_q       <= 1'b0;
      tick_cnt_q  <= '0;
      adj_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
      adj_field_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      dir_q       <= dir_d;
      // Prescalers restart from zero whenever their state is (re)entered.
      tick_cnt_q  <= (stay_run && !tick)        ? tick_cnt_q + 1'b1  : '0;
      adj_cnt_q   <= (stay_adjust && !adj_tick) ? adj_cnt_q + 1'b1   : '0;
      blink_cnt_q <= (stay_adjust && blink_cnt_q != BLINK_TERM) ? blink_cnt_q + 1'b1 : '0;
      blink_q     <= stay_adjust ? (blink_q ^ (blink_cnt_q == BLINK_TERM)) : 1'b0;
      running_q   <= (state_d == S_RUN);
      expired_q   <= (state_d == S_EXPIRED);
      adj_field_q <= (state_d == S_ADJUST) && bus.sel;
    end
  end

  assign bus.running   = running_q;
  assign bus.expired   = expired_q;
  assign bus.blink     = blink_q;
  assign bus.adj_field = adj_field_q;

`ifdef STOPWATCH_LAP_EN
  logic [15:0] lap_q, lap_d, digits_q;
  logic        hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    lap_d  = lap_q;
    if (state_d != S_RUN) begin
      hold_d = 1'b0;
    end else if (stay_run && bus.lap_pulse) begin
      hold_d = !hold_q;
      if (!hold_q) lap_d = value_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q    <= '0;
      hold_q   <= 1'b0;
      digits_q <= '0;
    end else begin
      lap_q    <= lap_d;
      hold_q   <= hold_d;
      digits_q <= hold_d ? lap_d : value_d;
    end
  end

  assign bus.digits = digits_q;
`else
  assign bus.digits = value_q;
`endif

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Directed self-checking bench for stopwatch_timer_core at CLK_HZ=16, TICK_HZ=1, ADJ_HZ=2, BLINK_HZ=2.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_stopwatch_timer_core;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  stopwatch_timer_core_if bus ();

  stopwatch_timer_core #(
    .CLK_HZ   (16),
    .TICK_HZ  (1),
    .ADJ_HZ   (2),
    .BLINK_HZ (2),
    .MAX_MIN  (59)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_pause();
    bus.pause_pulse = 1'b1;
    step(1);
    bus.pause_pulse = 1'b0;
  endtask

  task automatic pulse_lap();
    bus.lap_pulse = 1'b1;
    step(1);
    bus.lap_pulse = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    bus.pause_pulse = 1'b0;
    bus.lap_pulse   = 1'b0;
    bus.adj         = 1'b0;
    bus.sel         = 1'b0;
    bus.dir         = 1'b0;
    reset           = 1'b1;
    step(2);
    reset = 1'b0;
    check("rst_digits",    bus.digits,           16'h0000);
    check("rst_running",   16'(bus.running),     16'h0000);
    check("rst_expired",   16'(bus.expired),     16'h0000);
    check("rst_blink",     16'(bus.blink),       16'h0000);
    check("rst_adj_field", 16'(bus.adj_field),   16'h0000);

    // Up count: first change 17 edges after the start pulse, 01:01 after 61 ticks.
    bus.dir = 1'b0;
    pulse_pause();
    check("up_running", 16'(bus.running), 16'h0001);
    step(15);
    check("up_e16", bus.digits, 16'h0000);
    step(1);
    check("up_e17", bus.digits, 16'h0001);
    step(16 * 60);
    check("up_61ticks", bus.digits, 16'h0101);
    check("up_61_running", 16'(bus.running), 16'h0001);
    pulse_pause();
    check("pause_running", 16'(bus.running), 16'h0000);
    check("pause_digits",  bus.digits,       16'h0101);

    // Adjust minutes three times; blink toggles every 4 cycles.
    do_reset();
    check("rst_paused_digits", bus.digits, 16'h0000);
    bus.adj = 1'b1;
    bus.sel = 1'b0;
    step(1);
    check("adj_field_min", 16'(bus.adj_field), 16'h0000);
    check("adj_blink_e1",  16'(bus.blink),     16'h0000);
    step(3);
    check("adj_blink_e4",  16'(bus.blink),     16'h0000);
    step(1);
    check("adj_blink_e5",  16'(bus.blink),     16'h0001);
    step(3);
    check("adj_blink_e8",  16'(bus.blink),     16'h0001);
    check("adj_digits_e8", bus.digits,         16'h0000);
    step(1);
    check("adj_blink_e9",  16'(bus.blink),     16'h0000);
    check("adj_digits_e9", bus.digits,         16'h0100);
    step(15);
    check("adj_digits_e24", bus.digits, 16'h0200);
    bus.adj = 1'b0;
    step(1);
    check("adj_exit_digits", bus.digits,         16'h0300);
    check("adj_exit_blink",  16'(bus.blink),     16'h0000);
    check("adj_exit_run",    16'(bus.running),   16'h0000);
    pulse_pause();
    check("resume_running", 16'(bus.running), 16'h0001);
    step(16);
    check("resume_digits", bus.digits, 16'h0301);
    pulse_pause();

    // Countdown from 00:02 to expiry.
    do_reset();
    bus.adj = 1'b1;
    bus.sel = 1'b1;
    step(1);
    check("adj_field_sec", 16'(bus.adj_field), 16'h0001);
    step(16);
    check("preset_0002", bus.digits, 16'h0002);
    bus.adj = 1'b0;
    step(1);
    check("preset_hold",     bus.digits,         16'h0002);
    check("adj_field_clear", 16'(bus.adj_field), 16'h0000);
    bus.dir = 1'b1;
    pulse_pause();
    check("down_running", 16'(bus.running), 16'h0001);
    step(16);
    check("down_0001", bus.digits, 16'h0001);
    step(16);
    check("down_0000",    bus.digits,         16'h0000);
    check("down_expired", 16'(bus.expired),   16'h0001);
    check("down_stopped", 16'(bus.running),   16'h0000);
    step(20);
    check("expired_hold",   bus.digits,       16'h0000);
    check("expired_still",  16'(bus.expired), 16'h0001);
    pulse_pause();
    check("expired_clear",  16'(bus.expired), 16'h0000);
    check("idle_running",   16'(bus.running), 16'h0000);
    pulse_pause();
    check("idle_down_zero_ignored", 16'(bus.running), 16'h0000);
    bus.dir = 1'b0;

    // Load 59:58 and wrap through MAX_MIN:59.
    do_reset();
    bus.adj = 1'b1;
    bus.sel = 1'b0;
    step(1 + 8 * 59);
    check("load_min59", bus.digits, 16'h5900);
    bus.sel = 1'b1;
    step(8 * 58);
    check("load_5958", bus.digits, 16'h5958);
    bus.adj = 1'b0;
    step(1);
    pulse_pause();
    step(16);
    check("wrap_5959", bus.digits, 16'h5959);
    step(16);
    check("wrap_0000", bus.digits, 16'h0000);
    check("wrap_running", 16'(bus.running), 16'h0001);
    step(16);
    check("wrap_0001", bus.digits, 16'h0001);

    // Pause in the tick cycle discards the tick.
    step(15);
    check("tick_cycle_digits", bus.digits, 16'h0001);
    pulse_pause();
    check("pause_tick_digits",  bus.digits,       16'h0001);
    check("pause_tick_running", 16'(bus.running), 16'h0000);

    // Reset during RUN.
    pulse_pause();
    step(20);
    check("pre_reset_digits", bus.digits, 16'h0002);
    do_reset();
    check("run_reset_digits",  bus.digits,       16'h0000);
    check("run_reset_running", 16'(bus.running), 16'h0000);
    bus.dir = 1'b1;
    pulse_pause();
    check("reset_idle_down_ignored", 16'(bus.running), 16'h0000);
    bus.dir = 1'b0;

    // Lap pulse behaviour.
    do_reset();
    pulse_pause();
    step(80);
    check("lap_pre_0005", bus.digits, 16'h0005);
    pulse_lap();
`ifdef STOPWATCH_LAP_EN
    step(47);
    check("lap_frozen", bus.digits, 16'h0005);
    pulse_lap();
    check("lap_release", bus.digits, 16'h0008);
`else
    check("lap_ignored", bus.digits, 16'h0005);
    step(16);
    check("lap_ignored_live", bus.digits, 16'h0006);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
